// File: rtl/wb_mem_arbiter.sv
// Two-master (instruction/data) Wishbone arbiter onto one shared memory slave, round-robin on ties.
// Optional per-beat watchdog that raises err_o on a stalled slave: define WB_MEM_ARBITER_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wbi_cyc_i,
  input  logic            wbi_stb_i,
  input  logic            wbi_we_i,
  input  logic [AW-1:0]   wbi_adr_i,
  input  logic [DW/8-1:0] wbi_sel_i,
  input  logic [DW-1:0]   wbi_dat_i,
  output logic            wbi_ack_o,
  output logic            wbi_err_o,
  output logic [DW-1:0]   wbi_dat_o,
  input  logic            wbd_cyc_i,
  input  logic            wbd_stb_i,
  input  logic            wbd_we_i,
  input  logic [AW-1:0]   wbd_adr_i,
  input  logic [DW/8-1:0] wbd_sel_i,
  input  logic [DW-1:0]   wbd_dat_i,
  output logic            wbd_ack_o,
  output logic            wbd_err_o,
  output logic [DW-1:0]   wbd_dat_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic [DW-1:0]   wbs_dat_o,
  input  logic            wbs_ack_i,
  input  logic [DW-1:0]   wbs_dat_i
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e state_q, state_d;
  logic   lg_q, lg_d;   // last master granted: 0 = instruction, 1 = data
  logic   tmo;

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    case (state_q)
      IDLE: begin
        if (wbi_cyc_i && wbd_cyc_i) state_d = lg_q ? GNT_I : GNT_D;
        else if (wbi_cyc_i)         state_d = GNT_I;
        else if (wbd_cyc_i)         state_d = GNT_D;
      end
      GNT_I: begin
        if (!wbi_cyc_i) begin
          state_d = IDLE;
          lg_d    = 1'b0;
        end
      end
      GNT_D: begin
        if (!wbd_cyc_i) begin
          state_d = IDLE;
          lg_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
    end
  end

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYC);

  logic [CW-1:0] wdog_q, wdog_d;
  logic          gnt_stb;

  // Counts stalled strobe cycles of the current grant; depends only on registered state and the
  // slave ack, never feeding ack back into the request path except via the next-cycle register.
  always_comb begin
    gnt_stb = 1'b0;
    if (state_q == GNT_I)      gnt_stb = wbi_stb_i;
    else if (state_q == GNT_D) gnt_stb = wbd_stb_i;
    tmo    = (state_q != IDLE) && (wdog_q == TMO_LIM);
    wdog_d = wdog_q + CW'(1);
    if (state_q == IDLE || state_d != state_q || !gnt_stb || wbs_ack_i || tmo)
      wdog_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_sel_o = '0;
    wbs_dat_o = '0;
    wbi_ack_o = 1'b0;
    wbi_err_o = 1'b0;
    wbd_ack_o = 1'b0;
    wbd_err_o = 1'b0;
    case (state_q)
      GNT_I: begin
        wbs_cyc_o = wbi_cyc_i;
        wbs_stb_o = wbi_stb_i & ~tmo;
        wbs_we_o  = wbi_we_i;
        wbs_adr_o = wbi_adr_i;
        wbs_sel_o = wbi_sel_i;
        wbs_dat_o = wbi_dat_i;
        wbi_ack_o = wbs_ack_i;
        wbi_err_o = tmo;
      end
      GNT_D: begin
        wbs_cyc_o = wbd_cyc_i;
        wbs_stb_o = wbd_stb_i & ~tmo;
        wbs_we_o  = wbd_we_i;
        wbs_adr_o = wbd_adr_i;
        wbs_sel_o = wbd_sel_i;
        wbs_dat_o = wbd_dat_i;
        wbd_ack_o = wbs_ack_i;
        wbd_err_o = tmo;
      end
      default: ;
    endcase
  end

  assign wbi_dat_o = wbs_dat_i;
  assign wbd_dat_o = wbs_dat_i;

endmodule
